cdb_arbiter: RTL

- Producer end of the common data bus (CDB).
- Collects finished results from the ALU and the load/store buffer (LSB) into per-source FIFOs.
- Arbitrates round-robin between the two sources and broadcasts one (tag, value) pair per cycle.
- Reservation stations, the LSB and the ROB snoop the broadcast to wake operands and mark entries ready.

---
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: ALU/LSB result pushes and the CDB broadcast.
// slave = arbiter side, master = producers and snoopers.
interface cdb_arbiter_if #(
  parameter int ID_WIDTH  = 4,
  parameter int VAL_WIDTH = 32
);
  logic                 alu_valid;
  logic [ID_WIDTH-1:0]  alu_tag;
  logic [VAL_WIDTH-1:0] alu_val;
  logic                 alu_full;
  logic                 lsb_valid;
  logic [ID_WIDTH-1:0]  lsb_tag;
  logic [VAL_WIDTH-1:0] lsb_val;
  logic                 lsb_full;
  logic                 cdb_valid;
  logic [ID_WIDTH-1:0]  cdb_tag;
  logic [VAL_WIDTH-1:0] cdb_val;
  logic                 overflow;

  modport master (
    output alu_valid, alu_tag, alu_val,
    output lsb_valid, lsb_tag, lsb_val,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_tag, cdb_val,
    input  overflow
  );

  modport slave (
    input  alu_valid, alu_tag, alu_val,
    input  lsb_valid, lsb_tag, lsb_val,
    output alu_full, lsb_full,
    output cdb_valid, cdb_tag, cdb_val,
    output overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB producer: per-source result FIFOs, round-robin, one broadcast/cycle.
// Optional CDB_BYPASS_EN: a push into an empty winning FIFO skips it.
module cdb_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int VAL_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [ID_WIDTH-1:0]  tag_mem [2][FIFO_DEPTH];
  logic [VAL_WIDTH-1:0] val_mem [2][FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr  [2];
  logic [PW-1:0]        wr_ptr  [2];
  logic [CW-1:0]        cnt     [2];

  src_e                 last_grant;
  src_e                 grant;
  logic                 g;
  logic                 pop_any;

  logic [1:0]           in_valid;
  logic [ID_WIDTH-1:0]  in_tag [2];
  logic [VAL_WIDTH-1:0] in_val [2];

  logic [1:0]           full;
  logic [1:0]           acc;
  logic [1:0]           drop;
  logic [1:0]           avail;
  logic [1:0]           byp;
  logic [1:0]           rd_en;
  logic [1:0]           wr_en;

  logic [ID_WIDTH-1:0]  nxt_tag;
  logic [VAL_WIDTH-1:0] nxt_val;

  logic                 cdb_valid_q;
  logic [ID_WIDTH-1:0]  cdb_tag_q;
  logic [VAL_WIDTH-1:0] cdb_val_q;
  logic                 overflow_q;

  assign in_valid  = {bus.lsb_valid, bus.alu_valid};
  assign in_tag[0] = bus.alu_tag;
  assign in_tag[1] = bus.lsb_tag;
  assign in_val[0] = bus.alu_val;
  assign in_val[1] = bus.lsb_val;

  assign bus.alu_full  = full[0];
  assign bus.lsb_full  = full[1];
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_val   = cdb_val_q;
  assign bus.overflow  = overflow_q;

  // Push acceptance from the registered count; tag 0 is never a result.
  always_comb begin
    full  = '0;
    acc   = '0;
    drop  = '0;
    avail = '0;
    for (int s = 0; s < 2; s++) begin
      full[s] = cnt[s] == CW'(FIFO_DEPTH);
      acc[s]  = in_valid[s] && (in_tag[s] != '0) && !full[s];
      drop[s] = in_valid[s] && (in_tag[s] != '0) && full[s];
`ifdef CDB_BYPASS_EN
      avail[s] = (cnt[s] != '0) || acc[s];
`else
      avail[s] = cnt[s] != '0;
`endif
    end
  end

  // Round-robin: on contention the source not granted last time wins.
  always_comb begin
    grant   = SRC_ALU;
    pop_any = 1'b1;
    unique case (1'b1)
      (avail == 2'b11):
        grant = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
      (avail == 2'b01): grant = SRC_ALU;
      (avail == 2'b10): grant = SRC_LSB;
      default:          pop_any = 1'b0;
    endcase
  end

  assign g = (grant == SRC_LSB);

  // Read/write enables and the data that goes onto the bus.
  always_comb begin
    byp   = '0;
    rd_en = '0;
    wr_en = '0;
    for (int s = 0; s < 2; s++) begin
`ifdef CDB_BYPASS_EN
      byp[s] = pop_any && (g == 1'(s)) &&
               (cnt[s] == '0) && acc[s];
`endif
      rd_en[s] = pop_any && (g == 1'(s)) && !byp[s];
      wr_en[s] = acc[s] && !byp[s];
    end
    nxt_tag = byp[g] ? in_tag[g] : tag_mem[g][rd_ptr[g]];
    nxt_val = byp[g] ? in_val[g] : val_mem[g][rd_ptr[g]];
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (rdy_in && !flush) begin
      for (int s = 0; s < 2; s++) begin
        if (wr_en[s]) begin
          tag_mem[s][wr_ptr[s]] <= in_tag[s];
          val_mem[s][wr_ptr[s]] <= in_val[s];
        end
      end
    end
  end

  // Pointers, counts, grant history and the broadcast registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant  <= SRC_LSB;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      overflow_q  <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int s = 0; s < 2; s++) begin
          rd_ptr[s] <= '0;
          wr_ptr[s] <= '0;
          cnt[s]    <= '0;
        end
        last_grant  <= SRC_LSB;
        cdb_valid_q <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (wr_en[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
          if (rd_en[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
          cnt[s] <= cnt[s] + CW'(wr_en[s]) - CW'(rd_en[s]);
        end
        if (|drop) overflow_q <= 1'b1;
        cdb_valid_q <= pop_any;
        if (pop_any) begin
          cdb_tag_q  <= nxt_tag;
          cdb_val_q  <= nxt_val;
          last_grant <= grant;
        end
      end
    end
  end
endmodule
